// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the core run sequencer and its bench.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DONE,
    TIMEOUT
  } run_state_t;

  localparam int unsigned INSTR_WIDTH_DEF  = 9;
  localparam int unsigned CNT_WIDTH_DEF    = 16;
  localparam int unsigned START_CYCLES_DEF = 2;
  localparam logic [15:0] MAX_CYCLES_DEF   = 16'hFFF0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; flags the count sitting at, or about to hit, LIMIT.
module sat_counter #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o,
  output logic             hit_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign at_limit_o = (count_q == LIMIT);
  // Asserted on the increment that lands exactly on LIMIT.
  assign hit_o      = en_i && !clr_i && !at_limit_o && (count_q == LIMIT - WIDTH'(1));
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !at_limit_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer: pulses core start, enables the core, counts RUN cycles, and
// holds a halt or watchdog result until the host acknowledges it.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned          instr_width  = INSTR_WIDTH_DEF,
  parameter int unsigned          cnt_width    = CNT_WIDTH_DEF,
  parameter int unsigned          START_CYCLES = START_CYCLES_DEF,
  parameter logic [cnt_width-1:0] MAX_CYCLES   = cnt_width'(MAX_CYCLES_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [instr_width-1:0] go_addr,
  input  logic                   ack,
  input  logic                   core_halt,
  output logic                   core_start,
  output logic                   core_en,
  output logic [instr_width-1:0] start_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic [cnt_width-1:0]   instr_count
);

  localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  run_state_t             state_q, state_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic [instr_width-1:0] addr_q, addr_d;
  logic                   cnt_en, cnt_clr, cnt_at_limit, cnt_hit;

  sat_counter #(
    .WIDTH (cnt_width),
    .LIMIT (MAX_CYCLES)
  ) u_instr_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .count_o    (instr_count),
    .at_limit_o (cnt_at_limit),
    .hit_o      (cnt_hit)
  );

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    addr_d  = addr_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          addr_d  = go_addr;
          cnt_clr = 1'b1;
          scnt_d  = SW'(START_CYCLES - 1);
          state_d = START;
        end
      end
      START: begin
        if (scnt_q == '0) begin
          state_d = RUN;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end
      RUN: begin
        // Halt takes priority: a halting cycle is neither counted nor a timeout.
        if (core_halt) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit || cnt_at_limit) begin
            state_d = TIMEOUT;
          end
        end
      end
      DONE, TIMEOUT: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      addr_q  <= addr_d;
    end
  end

  // Outputs decode only the state register, so no input reaches an output combinationally.
  always_comb begin
    core_start = (state_q == START);
    core_en    = (state_q == START) || (state_q == RUN);
    busy       = (state_q == START) || (state_q == RUN);
    done       = (state_q == DONE) || (state_q == TIMEOUT);
    timed_out  = (state_q == TIMEOUT);
    start_addr = addr_q;
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a result scoreboard (watchdog limit shortened to 20).
module tb_core_run_ctrl;
  import run_ctrl_pkg::*;

  localparam logic [15:0] MAXC = 16'd20;

  typedef struct {
    logic [15:0] cnt;
    logic        to;
    logic [8:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, ack, core_halt;
  logic [8:0]  go_addr;
  logic        core_start, core_en, busy, done, timed_out;
  logic [8:0]  start_addr;
  logic [15:0] instr_count;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];

  core_run_ctrl #(
    .instr_width  (INSTR_WIDTH_DEF),
    .cnt_width    (CNT_WIDTH_DEF),
    .START_CYCLES (2),
    .MAX_CYCLES   (MAXC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .go_addr     (go_addr),
    .ack         (ack),
    .core_halt   (core_halt),
    .core_start  (core_start),
    .core_en     (core_en),
    .start_addr  (start_addr),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_start"}, 32'(core_start), 0);
    chk({tag, "_en"},    32'(core_en), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_to"},    32'(timed_out), 0);
  endtask

  // Accept a run request and walk through the two START cycles into RUN.
  task automatic run_start(input logic [8:0] addr, input logic halt_in_start);
    go = 1'b1;
    go_addr = addr;
    tick();
    go = 1'b0;
    core_halt = halt_in_start;
    chk("start1_core_start", 32'(core_start), 1);
    chk("start1_core_en", 32'(core_en), 1);
    chk("start1_busy", 32'(busy), 1);
    chk("start1_addr", 32'(start_addr), 32'(addr));
    chk("start1_count", 32'(instr_count), 0);
    tick();
    chk("start2_core_start", 32'(core_start), 1);
    tick();
    core_halt = 1'b0;
    chk("run_core_start", 32'(core_start), 0);
    chk("run_core_en", 32'(core_en), 1);
    chk("run_busy", 32'(busy), 1);
    chk("run_count0", 32'(instr_count), 0);
  endtask

  task automatic wait_result(input int exp_lat);
    int   n = 0;
    logic got = 1'b0;
    exp_t e;
    while (n < 64 && !got) begin
      tick();
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    chk("result_seen", 32'(got), 1);
    if (got) begin
      chk("result_latency", 32'(n), 32'(exp_lat));
      chk("sb_depth", 32'(sb.size()), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result_count", 32'(instr_count), 32'(e.cnt));
        chk("result_timed_out", 32'(timed_out), 32'(e.to));
        chk("result_addr", 32'(start_addr), 32'(e.addr));
        chk("result_core_en", 32'(core_en), 0);
        chk("result_busy", 32'(busy), 0);
      end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_idle("after_ack");
  endtask

  initial begin
    rst_n = 1'b0;
    go = 1'b0;
    ack = 1'b0;
    core_halt = 1'b0;
    go_addr = '0;
    #3;
    chk_idle("reset");
    chk("reset_addr", 32'(start_addr), 0);
    chk("reset_count", 32'(instr_count), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Normal run: five counted cycles then halt.
    run_start(9'h010, 1'b0);
    repeat (5) tick();
    chk("normal_still_run", 32'(busy), 1);
    core_halt = 1'b1;
    sb.push_back('{cnt: 16'd5, to: 1'b0, addr: 9'h010});
    wait_result(1);
    core_halt = 1'b0;

    // Hold the result without ack; it must stay frozen.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_done", 32'(done), 1);
      chk("hold_count", 32'(instr_count), 5);
    end
    // go together with ack must not start a run.
    ack = 1'b1;
    go = 1'b1;
    go_addr = 9'h0EE;
    tick();
    ack = 1'b0;
    go = 1'b0;
    chk_idle("ack_go");
    chk("ack_go_addr", 32'(start_addr), 32'h010);
    tick();
    chk("ack_go_idle", 32'(busy), 0);

    // Watchdog: no halt, timeout once the count reaches the limit.
    run_start(9'h1A5, 1'b0);
    repeat (int'(MAXC) - 1) tick();
    chk("wd_pre_busy", 32'(busy), 1);
    chk("wd_pre_count", 32'(instr_count), 32'(MAXC - 16'd1));
    sb.push_back('{cnt: MAXC, to: 1'b1, addr: 9'h1A5});
    wait_result(1);
    tick();
    chk("wd_hold_count", 32'(instr_count), 32'(MAXC));
    do_ack();

    // Halt during START is ignored; go while busy is ignored.
    run_start(9'h033, 1'b1);
    go = 1'b1;
    go_addr = 9'h1FF;
    tick();
    tick();
    go = 1'b0;
    tick();
    chk("busy_go_addr", 32'(start_addr), 32'h033);
    chk("busy_go_count", 32'(instr_count), 3);
    core_halt = 1'b1;
    sb.push_back('{cnt: 16'd3, to: 1'b0, addr: 9'h033});
    wait_result(1);
    core_halt = 1'b0;
    do_ack();

    // Halt on the cycle the counter would reach the limit: halt wins.
    run_start(9'h077, 1'b0);
    repeat (int'(MAXC) - 1) tick();
    core_halt = 1'b1;
    sb.push_back('{cnt: MAXC - 16'd1, to: 1'b0, addr: 9'h077});
    wait_result(1);
    core_halt = 1'b0;
    do_ack();

    // Asynchronous reset in the middle of RUN.
    run_start(9'h0AB, 1'b0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_idle("midrun_reset");
    chk("midrun_reset_count", 32'(instr_count), 0);
    chk("midrun_reset_addr", 32'(start_addr), 0);
    #3 rst_n = 1'b1;
    tick();
    chk_idle("after_midrun_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
